pipe_fetch: RTL and testbench

Fetch stage plus fetch-to-decode pipeline register for the 5-stage RV32I core. It is the producer side of the decode stage: it holds the PC, drives the instruction-memory address and captures instr/pc/pc+4 into the D-stage register. It honours stall and flush from the hazard unit and branch/jump redirects from execute. A redirect that arrives while fetch is stalled is held and applied when the stall releases.

---
 rtl/core_pkg.sv | 14 +
 rtl/fd_reg.sv | 43 ++++
 rtl/pipe_fetch.sv | 85 ++++++++
 tb/tb_pipe_fetch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline: datapath width, reset/bubble
// constants and the fetch redirect FSM encoding.
package core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fd_reg.sv
// Fetch-to-decode pipeline register with rst > flush > stall > load priority,
// plus a running count of real instructions handed to decode.
module fd_reg #(
    parameter int              XLEN      = core_pkg::XLEN,
    parameter logic [31:0]     NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            bubble,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic [31:0]     fetch_count
);

    // A bubble request only replaces a load; a stall still freezes the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_d     <= NOP_INSTR;
            pc_d        <= '0;
            pc_plus4_d  <= '0;
            valid_d     <= 1'b0;
            fetch_count <= '0;
        end else if (flush || (!stall && bubble)) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (!stall) begin
            instr_d     <= instr_in;
            pc_d        <= pc_in;
            pc_plus4_d  <= pc_in + XLEN'(4);
            valid_d     <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_fetch.sv
// Fetch stage: PC register with a RUN/HOLD redirect FSM that parks a redirect
// arriving during a fetch stall, feeding the F/D pipeline register.
module pipe_fetch #(
    parameter int              XLEN      = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = core_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    input  logic [31:0]     instr_f,
    output logic [XLEN-1:0] pc_f,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            redirect_pending,
    output logic [31:0]     fetch_count
);
    import core_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pend_tgt;
    logic [XLEN-1:0] tgt_aligned;

    assign tgt_aligned = pc_target_e & ~XLEN'(3);

    // In HOLD the newest redirect overwrites the parked one; on release a
    // same-cycle redirect is applied directly instead of the parked target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            pc_f             <= RESET_PC;
            pend_tgt         <= '0;
            redirect_pending <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (pc_src_e && !stall_f) begin
                        pc_f <= tgt_aligned;
                    end else if (pc_src_e) begin
                        pend_tgt         <= tgt_aligned;
                        state            <= HOLD;
                        redirect_pending <= 1'b1;
                    end else if (!stall_f) begin
                        pc_f <= pc_f + XLEN'(4);
                    end
                end
                HOLD: begin
                    if (pc_src_e) begin
                        pend_tgt <= tgt_aligned;
                    end
                    if (!stall_f) begin
                        pc_f             <= pc_src_e ? tgt_aligned : pend_tgt;
                        state            <= RUN;
                        redirect_pending <= 1'b0;
                    end
                end
            endcase
        end
    end

    fd_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_fd_reg (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush_d),
        .stall       (stall_d),
        .bubble      (state == HOLD),
        .instr_in    (instr_f),
        .pc_in       (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .fetch_count (fetch_count)
    );

endmodule

// File: tb/tb_pipe_fetch.sv
// Self-checking bench for pipe_fetch: table-driven vectors plus a hand-written
// redirect-during-stall sequence, checked through an expected-value queue.
module tb_pipe_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        redirect_pending;
    logic [31:0] fetch_count;

    typedef struct {
        logic        rst;
        logic        stall_f;
        logic        stall_d;
        logic        flush_d;
        logic        pc_src_e;
        logic [31:0] tgt;
        logic [31:0] exp_pc_f;
        logic        exp_valid;
        logic [31:0] exp_pc_d;
        logic        exp_pend;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs[30];
    vec_t sb_q[$];
    int   num_checks = 0;
    int   num_fails  = 0;

    pipe_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .stall_f          (stall_f),
        .stall_d          (stall_d),
        .flush_d          (flush_d),
        .pc_src_e         (pc_src_e),
        .pc_target_e      (pc_target_e),
        .instr_f          (instr_f),
        .pc_f             (pc_f),
        .instr_d          (instr_d),
        .pc_d             (pc_d),
        .pc_plus4_d       (pc_plus4_d),
        .valid_d          (valid_d),
        .redirect_pending (redirect_pending),
        .fetch_count      (fetch_count)
    );

    // Instruction memory returns a word tagged with its own address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    assign instr_f = imem_word(pc_f);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic sf, input logic sd, input logic fl,
                                input logic src, input logic [31:0] tgt, input logic [31:0] epc,
                                input logic ev, input logic [31:0] epcd, input logic ep,
                                input logic [31:0] ecnt);
        vec_t v;
        v.rst = r; v.stall_f = sf; v.stall_d = sd; v.flush_d = fl; v.pc_src_e = src;
        v.tgt = tgt; v.exp_pc_f = epc; v.exp_valid = ev; v.exp_pc_d = epcd;
        v.exp_pend = ep; v.exp_count = ecnt;
        return v;
    endfunction

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst         = v.rst;
        stall_f     = v.stall_f;
        stall_d     = v.stall_d;
        flush_d     = v.flush_d;
        pc_src_e    = v.pc_src_e;
        pc_target_e = v.tgt;
        sb_q.push_back(v);
    endtask

    // A valid F/D entry carries the tagged word of its PC; a bubble is all NOP/zero.
    task automatic checkOutput();
        vec_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            num_checks++;
            num_fails++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb_q.pop_front();
        check_field("pc_f", pc_f, e.exp_pc_f);
        check_field("valid_d", {31'd0, valid_d}, {31'd0, e.exp_valid});
        check_field("pc_d", pc_d, e.exp_pc_d);
        check_field("instr_d", instr_d, e.exp_valid ? imem_word(e.exp_pc_d) : NOP);
        check_field("pc_plus4_d", pc_plus4_d, e.exp_valid ? e.exp_pc_d + 32'd4 : 32'd0);
        check_field("redirect_pending", {31'd0, redirect_pending}, {31'd0, e.exp_pend});
        check_field("fetch_count", fetch_count, e.exp_count);
    endtask

    initial begin
        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src_e = 1'b0; pc_target_e = '0;

        //              rst sf sd fl src target         pc_f           v  pc_d           p  count
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,          32'h0,         0, 32'h0,         0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 32'h0,          32'h4,         1, 32'h0,         0, 1);
        vecs[2]  = mk(0, 0, 0, 0, 0, 32'h0,          32'h8,         1, 32'h4,         0, 2);
        vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0,          32'hC,         1, 32'h8,         0, 3);
        vecs[4]  = mk(0, 0, 0, 1, 1, 32'h103,        32'h100,       0, 32'h0,         0, 3);
        vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,          32'h104,       1, 32'h100,       0, 4);
        vecs[6]  = mk(0, 0, 0, 0, 1, 32'h20,         32'h20,        1, 32'h104,       0, 5);
        vecs[7]  = mk(0, 1, 1, 0, 0, 32'h0,          32'h20,        1, 32'h104,       0, 5);
        vecs[8]  = mk(0, 1, 1, 0, 0, 32'h0,          32'h20,        1, 32'h104,       0, 5);
        vecs[9]  = mk(0, 1, 1, 0, 0, 32'h0,          32'h20,        1, 32'h104,       0, 5);
        vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,          32'h24,        1, 32'h20,        0, 6);
        vecs[11] = mk(0, 1, 0, 0, 1, 32'h200,        32'h24,        1, 32'h24,        1, 7);
        vecs[12] = mk(0, 1, 0, 0, 1, 32'h300,        32'h24,        0, 32'h0,         1, 7);
        vecs[13] = mk(0, 1, 0, 0, 0, 32'h0,          32'h24,        0, 32'h0,         1, 7);
        vecs[14] = mk(0, 0, 0, 0, 0, 32'h0,          32'h300,       0, 32'h0,         0, 7);
        vecs[15] = mk(0, 0, 0, 0, 0, 32'h0,          32'h304,       1, 32'h300,       0, 8);
        vecs[16] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFF9,  32'hFFFF_FFF8, 1, 32'h304,       0, 9);
        vecs[17] = mk(0, 0, 0, 0, 0, 32'h0,          32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0, 10);
        vecs[18] = mk(0, 0, 0, 0, 0, 32'h0,          32'h0,         1, 32'hFFFF_FFFC, 0, 11);
        vecs[19] = mk(0, 0, 0, 0, 0, 32'h0,          32'h4,         1, 32'h0,         0, 12);
        vecs[20] = mk(0, 0, 1, 1, 0, 32'h0,          32'h8,         0, 32'h0,         0, 12);
        vecs[21] = mk(0, 0, 1, 0, 0, 32'h0,          32'hC,         0, 32'h0,         0, 12);
        vecs[22] = mk(0, 0, 0, 0, 0, 32'h0,          32'h10,        1, 32'hC,         0, 13);
        vecs[23] = mk(0, 1, 0, 0, 1, 32'h500,        32'h10,        1, 32'h10,        1, 14);
        vecs[24] = mk(0, 0, 0, 0, 1, 32'h604,        32'h604,       0, 32'h0,         0, 14);
        vecs[25] = mk(0, 0, 0, 0, 0, 32'h0,          32'h608,       1, 32'h604,       0, 15);
        vecs[26] = mk(0, 1, 0, 0, 1, 32'h400,        32'h608,       1, 32'h608,       1, 16);
        vecs[27] = mk(0, 1, 1, 0, 0, 32'h0,          32'h608,       1, 32'h608,       1, 16);
        vecs[28] = mk(1, 1, 0, 0, 0, 32'h0,          32'h0,         0, 32'h0,         0, 0);
        vecs[29] = mk(0, 0, 0, 0, 0, 32'h0,          32'h4,         1, 32'h0,         0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Redirects keep arriving for several stalled cycles; only the last survives.
        applyStimulus(mk(0, 1, 0, 0, 1, 32'h700, 32'h4, 1, 32'h4, 1, 2));
        checkOutput();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(mk(0, 1, 0, 0, 1, (i % 2 == 1) ? 32'h802 : 32'h700,
                             32'h4, 0, 32'h0, 1, 2));
            checkOutput();
        end
        applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, 32'h800, 0, 32'h0, 0, 2));
        checkOutput();
        applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, 32'h804, 1, 32'h800, 0, 3));
        checkOutput();

        if (sb_q.size() != 0) begin
            num_checks++;
            num_fails++;
            $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
